// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings for the data-memory responder: access-size
//            codes, FSM state encoding and wait-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access-size encodings carried on req_whb
  localparam logic [1:0] WHB_BYTE = 2'b00;
  localparam logic [1:0] WHB_HALF = 2'b01;
  localparam logic [1:0] WHB_WORD = 2'b10;
  localparam logic [1:0] WHB_RSVD = 2'b11;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wait counter holds WAIT_CYCLES-1, so 4 bits covers 0..15 wait states
  localparam int CNT_W = 4;

  // The reserved size code behaves as a word access wherever it is not
  // flagged as an error, so lane logic only ever sees three sizes.
  function automatic logic [1:0] norm_whb(input logic [1:0] whb);
    return (whb == WHB_RSVD) ? WHB_WORD : whb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_ctrl
// Purpose  : Combinational byte-lane steering. Produces the byte enables and
//            lane-replicated write word for stores, and the right-aligned,
//            zero-extended load value from a RAM word.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  whb,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  // Size decode: pick lanes, replicate store data, extract load data.
  // Half and word accesses ignore the low address bits below their size.
  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    rdata = rword;
    case (norm_whb(whb))
      WHB_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = {24'h000000, rword[{addr_lo, 3'b000} +: 8]};
      end
      WHB_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {16'h0000, (addr_lo[1] ? rword[31:16] : rword[15:0])};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Responder end of the core's data-memory port. One outstanding
//            load/store at a time over valid/ready request and response
//            channels, owns the data RAM, and inserts WAIT_CYCLES wait states.
// Config   : DMEM_ERR_CHECK_EN - when defined, misaligned, reserved-size and
//            out-of-range accesses return rsp_err=1 and suppress the store.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_whb,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              live;
  logic              accept;
  logic              access_err;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       lane_rdata;
  logic [31:0]       mem [DEPTH];

  // Goes high on the first clock after reset release; keeps req_ready low
  // throughout reset without feeding the async reset into datapath logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  assign req_ready = live && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IDX_W+1:2];
  assign rword     = mem[idx];

`ifdef DMEM_ERR_CHECK_EN
  assign access_err = (req_whb == WHB_RSVD)
                   || ((req_whb == WHB_HALF) && req_addr[0])
                   || ((req_whb == WHB_WORD) && (req_addr[1:0] != 2'b00))
                   || ((req_addr >> (IDX_W + 2)) != '0);
`else
  // Upper address bits wrap silently; only the index bits select the word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> (IDX_W + 2));
  assign access_err     = 1'b0;
`endif

  dmem_lane_ctrl u_lane_ctrl (
    .addr_lo (req_addr[1:0]),
    .whb     (req_whb),
    .wdata   (req_wdata),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .rdata   (lane_rdata)
  );

  // RAM store: commit enabled lanes at the accepting edge; never cleared.
  always_ff @(posedge clk) begin
    if (accept && req_we && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP
  // until the core takes the response.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (HAS_WAIT) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response capture at the accepting edge; held until the next accept.
  // Stores and erroring accesses return zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= access_err;
      rsp_rdata <= (req_we || access_err) ? 32'h0 : lane_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder. Two instances:
//            one with no wait states, one with three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic        rsp_ready;
  logic [1:0]  req_whb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] rsp_rdata3;

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  assign req_valid0 = req_valid && !sel;
  assign rsp_ready0 = rsp_ready && !sel;
  assign req_valid3 = req_valid && sel;
  assign rsp_ready3 = rsp_ready && sel;

  assign cur_req_ready = sel ? req_ready3 : req_ready0;
  assign cur_rsp_valid = sel ? rsp_valid3 : rsp_valid0;
  assign cur_rsp_err   = sel ? rsp_err3   : rsp_err0;
  assign cur_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .AW(32)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_whb   (req_whb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .AW(32)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_whb   (req_whb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_rdata (rsp_rdata3),
    .rsp_err   (rsp_err3)
  );

  int checks = 0;
  int errors = 0;
  int acc0   = 0;

  // Independent count of request handshakes on the zero-wait instance
  always @(posedge clk) begin
    if (req_valid0 && req_ready0) acc0 <= acc0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic s, input logic we, input logic [1:0] whb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    sel       = s;
    req_we    = we;
    req_whb   = whb;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (!cur_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chkb("accept_ready", cur_req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!cur_rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chkb("rsp_valid_seen", cur_rsp_valid, 1'b1);
  endtask

  task automatic do_txn(input logic s, input logic we, input logic [1:0] whb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd,
                        output logic er, output int lat);
    issue(s, we, whb, addr, wdata);
    wait_rsp(lat);
    rd = cur_rsp_rdata;
    er = cur_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chkb("bp_valid", cur_rsp_valid, 1'b1);
      chk ("bp_rdata", cur_rsp_rdata, rd);
      chkb("bp_err",   cur_rsp_err,   er);
      chkb("bp_ready", cur_req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chkb("idle_ready", cur_req_ready, 1'b1);
    chkb("idle_valid", cur_rsp_valid, 1'b0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          base;
    int          n;

    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_whb = WHB_WORD; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chkb("rst_req_ready0", req_ready0, 1'b0);
    chkb("rst_rsp_valid0", rsp_valid0, 1'b0);
    chk ("rst_rsp_rdata0", rsp_rdata0, 32'h0);
    chkb("rst_rsp_err0",   rsp_err0,   1'b0);
    chkb("rst_req_ready3", req_ready3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chkb("post_rst_ready0", req_ready0, 1'b1);

    // Word round-trip, zero wait states
    do_txn(1'b0, 1'b1, WHB_WORD, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk ("st_word_lat", lat, 1);
    chk ("st_word_rdata", rd, 32'h0);
    chkb("st_word_err", er, 1'b0);
    do_txn(1'b0, 1'b0, WHB_WORD, 32'h10, 32'h0, 0, rd, er, lat);
    chk ("ld_word_lat", lat, 1);
    chk ("ld_word_rdata", rd, 32'hDEADBEEF);
    chkb("ld_word_err", er, 1'b0);

    // Byte and half lanes
    do_txn(1'b0, 1'b1, WHB_WORD, 32'h20, 32'h11223344, 0, rd, er, lat);
    do_txn(1'b0, 1'b1, WHB_BYTE, 32'h22, 32'h000000AA, 0, rd, er, lat);
    do_txn(1'b0, 1'b0, WHB_WORD, 32'h20, 32'h0, 0, rd, er, lat);
    chk("ld_after_byte", rd, 32'h11AA3344);
    do_txn(1'b0, 1'b0, WHB_HALF, 32'h22, 32'h0, 0, rd, er, lat);
    chk("ld_half_hi", rd, 32'h000011AA);
    do_txn(1'b0, 1'b0, WHB_BYTE, 32'h23, 32'h0, 0, rd, er, lat);
    chk("ld_byte3", rd, 32'h00000011);
    do_txn(1'b0, 1'b0, WHB_BYTE, 32'h21, 32'h0, 0, rd, er, lat);
    chk("ld_byte1", rd, 32'h00000033);
    do_txn(1'b0, 1'b1, WHB_HALF, 32'h20, 32'hFFFFCAFE, 0, rd, er, lat);
    do_txn(1'b0, 1'b0, WHB_WORD, 32'h20, 32'h0, 0, rd, er, lat);
    chk("ld_after_half", rd, 32'h11AACAFE);

`ifdef DMEM_ERR_CHECK_EN
    // Misaligned store is rejected and leaves memory untouched
    do_txn(1'b0, 1'b1, WHB_WORD, 32'h22, 32'h99887766, 0, rd, er, lat);
    chkb("err_st_mis_err", er, 1'b1);
    chk ("err_st_mis_lat", lat, 1);
    do_txn(1'b0, 1'b0, WHB_WORD, 32'h20, 32'h0, 0, rd, er, lat);
    chk ("err_prior_data", rd, 32'h11AACAFE);
    chkb("err_prior_err", er, 1'b0);
    do_txn(1'b0, 1'b0, WHB_WORD, DEPTH * 4, 32'h0, 0, rd, er, lat);
    chkb("err_oor_err", er, 1'b1);
    chk ("err_oor_rdata", rd, 32'h0);
    do_txn(1'b0, 1'b0, WHB_RSVD, 32'h20, 32'h0, 0, rd, er, lat);
    chkb("err_rsvd_err", er, 1'b1);
    chk ("err_rsvd_rdata", rd, 32'h0);
    do_txn(1'b0, 1'b0, WHB_HALF, 32'h21, 32'h0, 0, rd, er, lat);
    chkb("err_half_err", er, 1'b1);
`else
    // Without checking, low bits are masked and the index wraps
    do_txn(1'b0, 1'b1, WHB_WORD, 32'h22, 32'h99887766, 0, rd, er, lat);
    chkb("mask_st_err", er, 1'b0);
    do_txn(1'b0, 1'b0, WHB_WORD, 32'h20, 32'h0, 0, rd, er, lat);
    chk ("mask_st_data", rd, 32'h99887766);
    do_txn(1'b0, 1'b0, WHB_WORD, DEPTH * 4 + 32'h20, 32'h0, 0, rd, er, lat);
    chk ("wrap_rdata", rd, 32'h99887766);
    chkb("wrap_err", er, 1'b0);
    do_txn(1'b0, 1'b0, WHB_RSVD, 32'h20, 32'h0, 0, rd, er, lat);
    chk ("rsvd_as_word", rd, 32'h99887766);
    do_txn(1'b0, 1'b0, WHB_HALF, 32'h21, 32'h0, 0, rd, er, lat);
    chk ("half_masked", rd, 32'h00007766);
`endif

    // Backpressure with three wait states
    do_txn(1'b1, 1'b1, WHB_WORD, 32'h30, 32'hCAFEF00D, 0, rd, er, lat);
    chk("w3_store_lat", lat, 4);
    do_txn(1'b1, 1'b0, WHB_WORD, 32'h30, 32'h0, 5, rd, er, lat);
    chk ("w3_load_lat", lat, 4);
    chk ("w3_load_rdata", rd, 32'hCAFEF00D);
    chkb("w3_load_err", er, 1'b0);

    // Reset while the store waits in WAIT
    issue(1'b1, 1'b1, WHB_WORD, 32'h40, 32'h5A5A1234);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chkb("midrst_wait_valid", rsp_valid3, 1'b0);
    chkb("midrst_wait_ready", req_ready3, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chkb("midrst_release_ready", req_ready3, 1'b1);

    // Reset while a load response is pending
    issue(1'b1, 1'b0, WHB_WORD, 32'h40, 32'h0);
    wait_rsp(lat);
    chk("midrst_ld_lat", lat, 4);
    chk("midrst_ld_rdata", rsp_rdata3, 32'h5A5A1234);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chkb("midrst_resp_valid", rsp_valid3, 1'b0);
    chk ("midrst_resp_rdata", rsp_rdata3, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_txn(1'b1, 1'b0, WHB_WORD, 32'h40, 32'h0, 0, rd, er, lat);
    chk("midrst_store_kept", rd, 32'h5A5A1234);

    // Back-to-back with req_valid and rsp_ready held high
    @(negedge clk);
    base      = acc0;
    sel       = 1'b0;
    rsp_ready = 1'b1;
    req_whb   = WHB_WORD;
    req_we    = 1'b1;
    req_addr  = 32'h80;
    req_wdata = 32'hA5000000;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (!req_ready0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chkb("b2b_ready", req_ready0, 1'b1);
      @(posedge clk);
      #1;
      chkb("b2b_rsp_valid", rsp_valid0, 1'b1);
      chk ("b2b_rdata", rsp_rdata0, (i < 10) ? 32'h0 : (32'hA5000000 | 32'(i - 10)));
      if (i < 19) begin
        req_we    = (i + 1) < 10;
        req_addr  = 32'h80 + 32'(4 * ((i + 1) % 10));
        req_wdata = 32'hA5000000 | 32'((i + 1) % 10);
      end else begin
        req_valid = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_accept_count", 32'(acc0 - base), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
